fetch_sequencer: RTL

- Instruction-fetch controller that owns the program counter and sequences instruction-memory accesses for the SEQ core.
- Issues one request at a time to the instruction memory over a valid/ready request channel with a valid-only response channel.
- Presents fetched instructions to decode over a valid/ready channel.
- Accepts branch redirects from execute and halts the core cleanly when the PC reaches the program limit.

---
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction-fetch controller for the SEQ core. Owns the program
//            counter, issues one instruction-memory request at a time,
//            hands fetched words to decode, follows branch redirects and
//            halts once the PC reaches PC_LIMIT.
// Ports    : clk, rst (async, active-low)
//            start                     - leave IDLE and begin fetching
//            imem_req_valid/ready/addr - request channel (addr == pc)
//            imem_resp_valid/data      - response channel (valid only)
//            inst_valid/ready/data/pc  - instruction channel to decode
//            redirect/redirect_target  - branch redirect from execute
//            busy, halted              - status
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'('h200),
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    // Instructions are word aligned: the two low target bits are discarded.
    localparam logic [ADDR_W-1:0] c_align_mask = ~(ADDR_W'(3));

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_drop;     // a response is still owed for a request that was redirected away
    logic [31:0]       r_inst_data;
    logic [ADDR_W-1:0] r_inst_pc;

    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_pc_ok;
    logic              w_next_ok;
    logic              w_target_ok;

    assign w_target    = redirect_target & c_align_mask;
    assign w_pc_next   = r_pc + ADDR_W'(4);     // wraps modulo 2^ADDR_W
    assign w_pc_ok     = (r_pc < PC_LIMIT);
    assign w_next_ok   = (w_pc_next < PC_LIMIT);
    assign w_target_ok = (w_target < PC_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_inst_data <= '0;
            r_inst_pc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_pc <= w_target;
                    end else if (start) begin
                        r_state <= w_pc_ok ? S_REQ : S_HALT;
                    end
                end

                S_REQ: begin
                    if (redirect) begin
                        r_pc <= w_target;
                        if (imem_req_ready) begin
                            // Request already accepted at the old pc: its
                            // response must be swallowed before refetching.
                            r_drop  <= 1'b1;
                            r_state <= S_WAIT;
                        end else if (!w_target_ok) begin
                            r_state <= S_HALT;
                        end
                    end else if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect) begin
                        r_pc <= w_target;
                        if (imem_resp_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= w_target_ok ? S_REQ : S_HALT;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= w_pc_ok ? S_REQ : S_HALT;
                        end else begin
                            r_inst_data <= imem_resp_data;
                            r_inst_pc   <= r_pc;
                            r_state     <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    // A redirect discards the held word even if decode takes
                    // it in the same cycle.
                    if (redirect) begin
                        r_pc    <= w_target;
                        r_state <= w_target_ok ? S_REQ : S_HALT;
                    end else if (inst_ready) begin
                        r_pc    <= w_pc_next;
                        r_state <= w_next_ok ? S_REQ : S_HALT;
                    end
                end

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst_data      = r_inst_data;
    assign inst_pc        = r_inst_pc;
    assign busy           = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted         = (r_state == S_HALT);

endmodule
`default_nettype wire
